// File: rtl/pe_seq_pkg.sv
// Shared definitions for the PE sequencer.
//   CYC_W_DEFAULT : default width of the cycle counts and cycle counters
//   state_t       : sequencer FSM state encoding (binary)
package pe_seq_pkg;

   localparam int unsigned CYC_W_DEFAULT = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAL  = 2'd1,
      ST_PASS = 2'd2,
      ST_END  = 2'd3
   } state_t;

endpackage

// File: rtl/pe_seq_cnt.sv
// Loadable down-counter with enable and terminal-count flag.
// The counter is loaded with (count - 1). It then steps down once per
// enabled cycle and stops at zero, so a count of 2^W-1 never wraps.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   load load_val (has priority over en)
//   load_val in   W   value to load
//   en       in   decrement by one, unless already at zero
//   cnt      out  W   current counter value
//   tc       out  terminal count: cnt is zero
module pe_seq_cnt #(
   parameter int unsigned W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign cnt = cnt_reg;
   assign tc  = (cnt_reg == '0);

endmodule

// File: rtl/pe_seq.sv
// PE tile sequencer. On rd_done it latches the accumulate and drain cycle
// counts, then walks IDLE -> CAL -> PASS -> END, generating the PE control
// strobes. pe_stall freezes CAL/PASS sequencing.
// Every output is a flop. The strobes for the cycle after an edge are
// decoded from the state before that edge and the inputs sampled at it, so
// an input never reaches an output without passing through a register.
//   clk_cal     in   clock, rising edge
//   rst_cal_n   in   asynchronous active-low reset
//   rd_done     in   operand read done: start a tile (sampled in IDLE only)
//   cal_cycle   in   CYC_W  accumulate cycle count, sampled on rd_done
//   pass_cycle  in   CYC_W  drain beat count, sampled on rd_done
//   pe_stall    in   hold sequencing while high (CAL/PASS)
//   acc_en      out  accumulator enable
//   acc_clr     out  first accumulate cycle: load instead of add
//   pass_en     out  result shift-out enable
//   Data_I_vld  out  result write to the in/out buffer (same as pass_en)
//   pass_idx    out  CYC_W  index of the current drain beat
//   pe_end      out  one-cycle tile-complete pulse
//   busy        out  sequencer is not idle
//   ovr_err     out  sticky: rd_done arrived while busy
module pe_seq
   import pe_seq_pkg::*;
#(
   parameter int unsigned CYC_W = CYC_W_DEFAULT
) (
   input  logic             clk_cal,
   input  logic             rst_cal_n,
   input  logic             rd_done,
   input  logic [CYC_W-1:0] cal_cycle,
   input  logic [CYC_W-1:0] pass_cycle,
   input  logic             pe_stall,
   output logic             acc_en,
   output logic             acc_clr,
   output logic             pass_en,
   output logic             Data_I_vld,
   output logic [CYC_W-1:0] pass_idx,
   output logic             pe_end,
   output logic             busy,
   output logic             ovr_err
);

   state_t state_reg, state_next;

   logic [CYC_W-1:0] cal_lat_reg;
   logic [CYC_W-1:0] pass_lat_reg;
   logic [CYC_W-1:0] cal_last;
   logic [CYC_W-1:0] pass_last;

   logic start;
   logic cal_beat;
   logic pass_beat;

   // Index 0: accumulate counter, index 1: drain counter.
   logic [1:0][CYC_W-1:0] cnt_ld_val;
   logic [1:0][CYC_W-1:0] cnt_q;
   logic [1:0]            cnt_en;
   logic [1:0]            cnt_tc;

   logic             acc_en_reg;
   logic             acc_clr_reg;
   logic             pass_en_reg;
   logic [CYC_W-1:0] pass_idx_reg;
   logic             pe_end_reg;
   logic             busy_reg;
   logic             ovr_err_reg;

   assign start     = (state_reg == ST_IDLE) && rd_done;
   assign cal_beat  = (state_reg == ST_CAL)  && !pe_stall;
   assign pass_beat = (state_reg == ST_PASS) && !pe_stall;

   assign cal_last  = cal_lat_reg  - CYC_W'(1);
   assign pass_last = pass_lat_reg - CYC_W'(1);

   // A zero count loads all-ones here, but that counter is never run:
   // the FSM skips the corresponding state.
   assign cnt_ld_val[0] = cal_cycle  - CYC_W'(1);
   assign cnt_ld_val[1] = pass_cycle - CYC_W'(1);
   assign cnt_en        = {pass_beat, cal_beat};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         pe_seq_cnt #(
            .W (CYC_W)
         ) u_cnt (
            .clk      (clk_cal),
            .rst_n    (rst_cal_n),
            .load     (start),
            .load_val (cnt_ld_val[gi]),
            .en       (cnt_en[gi]),
            .cnt      (cnt_q[gi]),
            .tc       (cnt_tc[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         cal_lat_reg  <= '0;
         pass_lat_reg <= '0;
      end else if (start) begin
         cal_lat_reg  <= cal_cycle;
         pass_lat_reg <= pass_cycle;
      end
   end

   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rd_done) begin
               if (cal_cycle != '0) begin
                  state_next = ST_CAL;
               end else if (pass_cycle != '0) begin
                  state_next = ST_PASS;
               end else begin
                  state_next = ST_END;
               end
            end
         end
         ST_CAL: begin
            if (cal_beat && cnt_tc[0]) begin
               state_next = (pass_lat_reg != '0) ? ST_PASS : ST_END;
            end
         end
         ST_PASS: begin
            if (pass_beat && cnt_tc[1]) begin
               state_next = ST_END;
            end
         end
         ST_END: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered strobes. acc_clr marks the first accumulate cycle (counter
   // still at its loaded value), so it stays up while that cycle is stalled.
   always_ff @(posedge clk_cal or negedge rst_cal_n) begin
      if (!rst_cal_n) begin
         acc_en_reg   <= 1'b0;
         acc_clr_reg  <= 1'b0;
         pass_en_reg  <= 1'b0;
         pass_idx_reg <= '0;
         pe_end_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         ovr_err_reg  <= 1'b0;
      end else begin
         acc_en_reg  <= cal_beat;
         acc_clr_reg <= (state_reg == ST_CAL) && (cnt_q[0] == cal_last);
         pass_en_reg <= pass_beat;
         if (start) begin
            pass_idx_reg <= '0;
         end else if (pass_beat) begin
            pass_idx_reg <= pass_last - cnt_q[1];
         end
         pe_end_reg  <= (state_reg == ST_END);
         busy_reg    <= (state_reg != ST_IDLE);
         ovr_err_reg <= ovr_err_reg | (rd_done && (state_reg != ST_IDLE));
      end
   end

   assign acc_en     = acc_en_reg;
   assign acc_clr    = acc_clr_reg;
   assign pass_en    = pass_en_reg;
   assign Data_I_vld = pass_en_reg;
   assign pass_idx   = pass_idx_reg;
   assign pe_end     = pe_end_reg;
   assign busy       = busy_reg;
   assign ovr_err    = ovr_err_reg;

endmodule

// File: tb/tb_pe_seq.sv
// Scoreboard bench for pe_seq. Stimulus pushes the expected output beats
// (cycle, strobes, drain index) into a queue when it issues a tile; a
// monitor pops and compares whenever the DUT shows acc_en, pass_en or
// pe_end. Cycle numbers count rising edges; outputs are sampled on the
// falling edge, inputs are driven on the falling edge.
module tb_pe_seq;

   localparam int W = 11;

   logic         clk_cal    = 1'b0;
   logic         rst_cal_n  = 1'b1;
   logic         rd_done    = 1'b0;
   logic [W-1:0] cal_cycle  = '0;
   logic [W-1:0] pass_cycle = '0;
   logic         pe_stall   = 1'b0;
   logic         acc_en;
   logic         acc_clr;
   logic         pass_en;
   logic         Data_I_vld;
   logic [W-1:0] pass_idx;
   logic         pe_end;
   logic         busy;
   logic         ovr_err;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      int   cyc;
      logic acc;
      logic clr;
      logic pas;
      int   idx;
      logic pend;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   pe_seq #(.CYC_W(W)) dut (
      .clk_cal    (clk_cal),
      .rst_cal_n  (rst_cal_n),
      .rd_done    (rd_done),
      .cal_cycle  (cal_cycle),
      .pass_cycle (pass_cycle),
      .pe_stall   (pe_stall),
      .acc_en     (acc_en),
      .acc_clr    (acc_clr),
      .pass_en    (pass_en),
      .Data_I_vld (Data_I_vld),
      .pass_idx   (pass_idx),
      .pe_end     (pe_end),
      .busy       (busy),
      .ovr_err    (ovr_err)
   );

   always #5 clk_cal = ~clk_cal;

   always @(posedge clk_cal) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_acc_en"},     32'(acc_en),     0);
      chk({tag, "_acc_clr"},    32'(acc_clr),    0);
      chk({tag, "_pass_en"},    32'(pass_en),    0);
      chk({tag, "_data_i_vld"}, 32'(Data_I_vld), 0);
      chk({tag, "_pass_idx"},   32'(pass_idx),   0);
      chk({tag, "_pe_end"},     32'(pe_end),     0);
      chk({tag, "_busy"},       32'(busy),       0);
      chk({tag, "_ovr_err"},    32'(ovr_err),    0);
   endtask

   function automatic void push_ev(int c, logic a, logic cl, logic p, int idx, logic e);
      ev_t ev;
      ev.cyc  = c;
      ev.acc  = a;
      ev.clr  = cl;
      ev.pas  = p;
      ev.idx  = idx;
      ev.pend = e;
      exp_q.push_back(ev);
   endfunction

   // Monitor: every cycle with activity must match the next expected beat.
   always @(negedge clk_cal) begin
      if (acc_en || pass_en || pe_end) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got acc_en=%0b pass_en=%0b pe_end=%0b, required no activity (cycle %0d)",
                     acc_en, pass_en, pe_end, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat_cycle", 32'(cyc),        32'(mon_e.cyc));
            chk("acc_en",     32'(acc_en),     32'(mon_e.acc));
            chk("acc_clr",    32'(acc_clr),    32'(mon_e.clr));
            chk("pass_en",    32'(pass_en),    32'(mon_e.pas));
            chk("data_i_vld", 32'(Data_I_vld), 32'(mon_e.pas));
            chk("pe_end",     32'(pe_end),     32'(mon_e.pend));
            if (mon_e.pas) chk("pass_idx", 32'(pass_idx), 32'(mon_e.idx));
         end
      end
   end

   // Drives rd_done for one cycle and queues the expected beats. A stall of
   // st_len cycles beginning at edge t+st_at pushes every beat at or after
   // that edge later by st_len. Returns at the falling edge after edge t.
   task automatic issue_tile(input int cal, input int pas, input int st_at,
                             input int st_len, output int t);
      int c;
      int last;
      @(negedge clk_cal);
      rd_done    = 1'b1;
      cal_cycle  = W'(cal);
      pass_cycle = W'(pas);
      t    = cyc + 1;
      last = t;
      for (int i = 0; i < cal; i++) begin
         c = t + 1 + i;
         if (st_len > 0 && c >= t + st_at) c += st_len;
         push_ev(c, 1'b1, (i == 0), 1'b0, 0, 1'b0);
         last = c;
      end
      for (int j = 0; j < pas; j++) begin
         c = t + 1 + cal + j;
         if (st_len > 0 && c >= t + st_at) c += st_len;
         push_ev(c, 1'b0, 1'b0, 1'b1, j, 1'b0);
         last = c;
      end
      push_ev(last + 1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      $display("tile: t=%0d cal_cycle=%0d pass_cycle=%0d stall_at=t+%0d stall_len=%0d pe_end_at=%0d",
               t, cal, pas, st_at, st_len, last + 1);
      @(negedge clk_cal);
      rd_done = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_cal);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(negedge clk_cal);
         #1;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   initial begin
      int t;

      // Reset
      #1 rst_cal_n = 1'b0;
      repeat (3) @(negedge clk_cal);
      #1 chk_all_zero("reset");
      @(negedge clk_cal);
      rst_cal_n = 1'b1;
      repeat (2) @(negedge clk_cal);

      // Nominal 4/3 tile
      issue_tile(4, 3, 0, 0, t);
      wait_until(t + 1);
      chk("nominal_busy", 32'(busy), 1);
      wait_until(t + 8);
      chk("nominal_pe_end_t8", 32'(pe_end), 1);
      wait_drain(20);
      wait_until(t + 9);
      chk("nominal_busy_after", 32'(busy), 0);
      chk("nominal_ovr_err", 32'(ovr_err), 0);

      // Zero accumulate count
      issue_tile(0, 2, 0, 0, t);
      wait_until(t + 3);
      chk("zero_cal_pe_end_t3", 32'(pe_end), 1);
      wait_drain(20);
      @(negedge clk_cal);

      // Both counts zero, stall held throughout (no effect in IDLE/END)
      pe_stall = 1'b1;
      issue_tile(0, 0, 0, 0, t);
      wait_until(t + 1);
      chk("zero_both_pe_end_t1", 32'(pe_end), 1);
      wait_drain(20);
      pe_stall = 1'b0;
      @(negedge clk_cal);

      // Stall for two cycles from t+2 in a 3/2 tile
      issue_tile(3, 2, 2, 2, t);
      @(negedge clk_cal);
      pe_stall = 1'b1;
      repeat (2) @(negedge clk_cal);
      pe_stall = 1'b0;
      wait_until(t + 8);
      chk("stall_pe_end_t8", 32'(pe_end), 1);
      wait_drain(20);
      @(negedge clk_cal);

      // Overrun: second rd_done at t+2 with different counts, ignored
      issue_tile(4, 3, 0, 0, t);
      @(negedge clk_cal);
      chk("overrun_ovr_before", 32'(ovr_err), 0);
      rd_done    = 1'b1;
      cal_cycle  = W'(1);
      pass_cycle = W'(0);
      @(negedge clk_cal);
      rd_done = 1'b0;
      wait_until(t + 3);
      chk("overrun_ovr_t3", 32'(ovr_err), 1);
      wait_until(t + 8);
      chk("overrun_pe_end_t8", 32'(pe_end), 1);
      wait_drain(20);
      wait_until(t + 12);
      chk("overrun_ovr_held", 32'(ovr_err), 1);

      // Reset mid-tile: the aborted tile produces nothing more
      issue_tile(4, 3, 0, 0, t);
      repeat (2) @(negedge clk_cal);
      #2 rst_cal_n = 1'b0;
      exp_q.delete();
      #1 chk_all_zero("midreset");
      repeat (3) @(negedge clk_cal);
      rst_cal_n = 1'b1;
      repeat (12) @(negedge clk_cal);
      #1 chk("midreset_no_pe_end_busy", 32'(busy), 0);
      issue_tile(4, 3, 0, 0, t);
      wait_until(t + 8);
      chk("after_reset_pe_end_t8", 32'(pe_end), 1);
      wait_drain(20);
      chk("after_reset_ovr_err", 32'(ovr_err), 0);
      @(negedge clk_cal);

      // Maximum count
      issue_tile(2047, 1, 0, 0, t);
      wait_until(t + 2048);
      chk("max_pass_beat", 32'(pass_en), 1);
      wait_until(t + 2049);
      chk("max_pe_end", 32'(pe_end), 1);
      wait_drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
